// File: rtl/morse_unit_serializer.sv
// Serializes one Morse character (unit pattern + unit count) onto a registered key line, MSB first,
// one unit per UNIT_CYCLES clocks. Optional square-wave tone output is enabled by defining MORSE_TONE_EN.
module morse_unit_serializer #(
   parameter int UNIT_CYCLES      = 6_000_000,
   parameter int PAT_W            = 21,
   parameter int LEN_W            = 5,
   parameter int TONE_HALF_CYCLES = 62_500
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [LEN_W-1:0] in_len,
   input  logic [PAT_W-1:0] in_pattern,
   output logic             key_out,
   output logic             busy,
   output logic             done
`ifdef MORSE_TONE_EN
   ,
   output logic             tone_out
`endif
);

   localparam int CNT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int UL_W  = $clog2(PAT_W + 1);

   localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
   localparam logic [UL_W-1:0]  PAT_W_U   = UL_W'(PAT_W);

   if (UNIT_CYCLES < 2) begin : g_bad_unit_cycles
      $error("morse_unit_serializer: UNIT_CYCLES must be >= 2");
   end
   if (TONE_HALF_CYCLES < 1) begin : g_bad_tone_half
      $error("morse_unit_serializer: TONE_HALF_CYCLES must be >= 1");
   end

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [PAT_W-1:0] shift_q, shift_d;
   logic [UL_W-1:0]  units_q, units_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             key_d;
   logic             done_d;
   logic [UL_W-1:0]  len_eff;
   logic             accept;

   // Counts longer than the pattern register are clamped so the shifter never underflows.
   always_comb begin
      len_eff = UL_W'(in_len);
      if (32'(in_len) > 32'(PAT_W)) len_eff = PAT_W_U;
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state == SEND);
   assign accept   = in_valid && in_ready;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state;
      shift_d = shift_q;
      units_d = units_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      unique case (state)
         IDLE: begin
            if (accept) begin
               if (len_eff == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = SEND;
                  // Left-justify so the first unit sits at the MSB; unused upper bits fall off.
                  shift_d = in_pattern << (PAT_W_U - len_eff);
                  units_d = len_eff;
                  cnt_d   = UNIT_LAST;
               end
            end
         end
         SEND: begin
            if (cnt_q == '0) begin
               cnt_d   = UNIT_LAST;
               shift_d = shift_q << 1;
               units_d = units_q - UL_W'(1);
               if (units_q == UL_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Key is registered from the next-state view so it changes together with the state.
      key_d = (state_d == SEND) && shift_d[PAT_W-1];
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         shift_q <= '0;
         units_q <= '0;
         cnt_q   <= '0;
         key_out <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_d;
         shift_q <= shift_d;
         units_q <= units_d;
         cnt_q   <= cnt_d;
         key_out <= key_d;
         done    <= done_d;
      end
   end

`ifdef MORSE_TONE_EN
   localparam int TONE_W = (TONE_HALF_CYCLES > 1) ? $clog2(TONE_HALF_CYCLES) : 1;
   localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF_CYCLES - 1);

   logic [TONE_W-1:0] tone_cnt;

   // Tone phase restarts at every key-down edge so each element begins with a low half-period.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tone_cnt <= '0;
         tone_out <= 1'b0;
      end else if (!key_d || !key_out) begin
         tone_cnt <= '0;
         tone_out <= 1'b0;
      end else if (tone_cnt == TONE_LAST) begin
         tone_cnt <= '0;
         tone_out <= ~tone_out;
      end else begin
         tone_cnt <= tone_cnt + TONE_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_morse_unit_serializer.sv
// Self-checking bench for morse_unit_serializer: directed literal cases plus randomized traffic
// compared every cycle against a per-character timing model.
module tb_morse_unit_serializer;

   localparam int U     = 4;
   localparam int HALF  = 2;
   localparam int PAT_W = 21;
   localparam int LEN_W = 5;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [LEN_W-1:0] in_len = '0;
   logic [PAT_W-1:0] in_pattern = '0;
   logic             key_out;
   logic             busy;
   logic             done;
`ifdef MORSE_TONE_EN
   logic             tone_out;
`endif

   morse_unit_serializer #(
      .UNIT_CYCLES(U),
      .PAT_W(PAT_W),
      .LEN_W(LEN_W),
      .TONE_HALF_CYCLES(HALF)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_len(in_len),
      .in_pattern(in_pattern),
      .key_out(key_out),
      .busy(busy),
      .done(done)
`ifdef MORSE_TONE_EN
      ,
      .tone_out(tone_out)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: last accepted character and the cycle it was accepted in.
   int               cyc      = 0;
   bit               seen_rst = 1'b0;
   bit               m_active = 1'b0;
   int               m_acc    = -100;
   int               m_len    = 0;
   logic [PAT_W-1:0] m_pat    = '0;
   bit               rdy_pre;
   int               run_k    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model_exp(output bit k, output bit b, output bit r, output bit d);
      int rr;
      int tot;
      rr  = cyc - m_acc;
      tot = m_len * U;
      k = 1'b0; b = 1'b0; r = 1'b1; d = 1'b0;
      if (m_active) begin
         if (rr >= 1 && rr <= tot) begin
            b = 1'b1;
            r = 1'b0;
            k = m_pat[m_len - 1 - (rr - 1) / U];
         end else if (rr == tot + 1) begin
            d = 1'b1;
         end
      end
   endfunction

   function automatic bit m_ready();
      bit k, b, r, d;
      model_exp(k, b, r, d);
      return r;
   endfunction

   always @(posedge clk) begin
      rdy_pre = m_ready();
      cyc++;
      if (!rst_n) begin
         m_active = 1'b0;
         seen_rst = 1'b1;
      end else if (seen_rst && rdy_pre && in_valid) begin
         m_active = 1'b1;
         m_acc    = cyc - 1;
         m_len    = (int'(in_len) > PAT_W) ? PAT_W : int'(in_len);
         m_pat    = in_pattern;
      end
   end

   always @(negedge clk) begin
      bit ek, eb, er, ed;
      if (seen_rst) begin
         model_exp(ek, eb, er, ed);
         check("key_out", 32'(key_out), 32'(ek));
         check("busy", 32'(busy), 32'(eb));
         check("in_ready", 32'(in_ready), 32'(er));
         check("done", 32'(done), 32'(ed));
`ifdef MORSE_TONE_EN
         check("tone_out", 32'(tone_out), 32'(ek && (((run_k / HALF) % 2) == 1)));
         run_k = ek ? run_k + 1 : 0;
`endif
      end
   end

   // Sends one character from a negedge and checks literal key/busy/done per relative cycle.
   task automatic send_lit(input string name, input int len, input logic [PAT_W-1:0] pat,
                           input bit hold, input logic [127:0] exp_key, input int done_r,
                           input bit chk_tone, input logic [127:0] exp_tone);
      int waitc = 0;
      bit ek;
      in_len     = LEN_W'(len);
      in_pattern = pat;
      in_valid   = 1'b1;
      while (!m_ready()) begin
         @(negedge clk);
         waitc++;
         if (waitc > 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: accept timeout, actual not-ready required ready", name);
            return;
         end
      end
      @(negedge clk);
      if (!hold) in_valid = 1'b0;
      for (int r = 1; r <= done_r; r++) begin
         ek = (r < done_r) ? exp_key[done_r - 1 - r] : 1'b0;
         check({name, "_key"}, 32'(key_out), 32'(ek));
         check({name, "_busy"}, 32'(busy), 32'(r < done_r));
         check({name, "_done"}, 32'(done), 32'(r == done_r));
`ifdef MORSE_TONE_EN
         if (chk_tone && r < done_r) check({name, "_tone"}, 32'(tone_out), 32'(exp_tone[done_r - 1 - r]));
`else
         if (chk_tone && r < done_r && exp_tone[done_r - 1 - r]) ek = 1'b0;
`endif
         if (r < done_r) @(negedge clk);
      end
   endtask

   initial begin
      logic [127:0] ones84;
      ones84 = (128'd1 << 84) - 128'd1;

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("reset_ready", 32'(in_ready), 32'd1);
      check("reset_key", 32'(key_out), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      @(negedge clk);

      send_lit("E", 3, 21'b100, 1'b0, 128'hF00, 13, 1'b1, 128'h300);
      @(negedge clk);
      send_lit("A", 7, 21'b1011100, 1'b0, 128'hF0FFF00, 29, 1'b0, '0);
      @(negedge clk);
      send_lit("space", 3, 21'b0, 1'b1, 128'h000, 13, 1'b0, '0);
      send_lit("T", 5, 21'b11100, 1'b0, 128'hFFF00, 21, 1'b0, '0);
      @(negedge clk);
      send_lit("len0", 0, 21'h1FFFFF, 1'b0, 128'h0, 1, 1'b0, '0);
      @(negedge clk);
      send_lit("len25", 25, 21'h1FFFFF, 1'b0, ones84, 85, 1'b0, '0);

      // Reset in cycle 6 of a dash.
      in_len = LEN_W'(5); in_pattern = 21'b11100; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      check("rst_mid_key_before", 32'(key_out), 32'd1);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("rst_mid_key", 32'(key_out), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 30; i++) begin
         check("rst_mid_no_done", 32'(done), 32'd0);
         @(negedge clk);
      end

      // Randomized traffic; producer holds each character until it is accepted.
      for (int i = 0; i < 8000; i++) begin
         if (in_valid && m_active && m_acc == cyc - 1) in_valid = 1'b0;
         if (!in_valid && $urandom_range(0, 3) == 0) begin
            in_len     = ($urandom_range(0, 7) == 0) ? LEN_W'($urandom_range(0, 31))
                                                     : LEN_W'($urandom_range(1, 10));
            in_pattern = PAT_W'($urandom);
            in_valid   = 1'b1;
         end else if (!in_valid) begin
            in_len     = LEN_W'($urandom);
            in_pattern = PAT_W'($urandom);
         end
         rst_n = ($urandom_range(0, 599) == 0) ? 1'b0 : 1'b1;
         @(negedge clk);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      repeat (120) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
